// File: rtl/mul_div_unit_pkg.sv
// Shared op-type package for the iterative multiply/divide unit.
// Holds the operation encoding, FSM state enum and width constants.
package mul_div_unit_pkg;

  typedef enum logic [2:0] {
    MDT_MUL    = 3'd0,
    MDT_MULH   = 3'd1,
    MDT_MULHSU = 3'd2,
    MDT_MULHU  = 3'd3,
    MDT_DIV    = 3'd4,
    MDT_DIVU   = 3'd5,
    MDT_REM    = 3'd6,
    MDT_REMU   = 3'd7
  } MulDivType;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    CALC,
    FIXUP,
    DONE
  } MulDivState;

  localparam int W32 = 32;

  function automatic logic is_div_op(input MulDivType t);
    return t[2];
  endfunction

  function automatic logic is_rem_op(input MulDivType t);
    return t[2] & t[1];
  endfunction

  function automatic logic src1_signed(input MulDivType t);
    return (t == MDT_MULH) || (t == MDT_MULHSU) ||
           (t == MDT_DIV)  || (t == MDT_REM);
  endfunction

  function automatic logic src2_signed(input MulDivType t);
    return (t == MDT_MULH) || (t == MDT_DIV) ||
           (t == MDT_REM);
  endfunction

endpackage

// File: rtl/mul_div_step.sv
// One combinational iteration: shift-add multiply or restoring divide.
// Ports: is_div selects op, opnd = multiplicand/divisor, acc_i -> acc_o.
module mul_div_step
  import mul_div_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              is_div,
  input  logic [XLEN-1:0]   opnd,
  input  logic [2*XLEN-1:0] acc_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [XLEN:0] sum;
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;

  always_comb begin
    sum    = {1'b0, acc_i[2*XLEN-1:XLEN]} +
             (acc_i[0] ? {1'b0, opnd} : '0);
    // the shifted partial remainder needs one extra bit
    rem_sh = acc_i[2*XLEN-1:XLEN-1];
    diff   = rem_sh - {1'b0, opnd};
    if (is_div) begin
      if (diff[XLEN]) begin
        acc_o = {rem_sh[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
      end else begin
        acc_o = {diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
      end
    end else begin
      acc_o = {sum, acc_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RISC-V M-extension mul/div unit, STEP_BITS bits per cycle.
// Ports: inValid/inReady request, src1/src2/mulDivType/isWord operands,
// flush abort, outValid/outReady/result response; async rstN.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int STEP_BITS = 1
) (
  input  logic            clk,
  input  logic            rstN,
  input  logic            inValid,
  output logic            inReady,
  input  MulDivType       mulDivType,
  input  logic            isWord,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            outValid,
  input  logic            outReady,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN);
  localparam int SHW   = XLEN - W32;
  localparam logic [CNT_W-1:0] LAST_X =
    CNT_W'(XLEN / STEP_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_W =
    CNT_W'(W32 / STEP_BITS - 1);

  MulDivState        state_q, state_d;
  MulDivType         op_q, op_d;
  logic              w_q, w_d;
  logic              res_neg_q, res_neg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              accept;
  logic              is_div;
  logic              is_rem;
  logic              calc_last;
  logic              neg_a, neg_b;
  logic              b_zero, ovf, fast;
  logic [XLEN-1:0]   a_ext, b_ext;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN-1:0]   min_neg;
  logic [XLEN-1:0]   fast_val, fix_val;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem;
  logic [2*XLEN-1:0] chain [STEP_BITS+1];

  function automatic logic [XLEN-1:0] fmt(
    input logic [XLEN-1:0] v,
    input logic            w
  );
    return w ? XLEN'($signed(v[W32-1:0])) : v;
  endfunction

  assign accept    = inValid && inReady && !flush;
  assign is_div    = is_div_op(op_q);
  assign is_rem    = is_rem_op(op_q);
  assign calc_last = cnt_q == (w_q ? LAST_W : LAST_X);

  assign chain[0] = acc_q;
  for (genvar g = 0; g < STEP_BITS; g++) begin : g_step
    mul_div_step #(
      .XLEN(XLEN)
    ) u_step (
      .is_div(is_div),
      .opnd  (opnd_q),
      .acc_i (chain[g]),
      .acc_o (chain[g+1])
    );
  end

  // operand conditioning used in PREP
  always_comb begin
    a_ext = acc_q[XLEN-1:0];
    b_ext = opnd_q;
    if (w_q) begin
      a_ext = src1_signed(op_q)
            ? XLEN'($signed(acc_q[W32-1:0]))
            : XLEN'(acc_q[W32-1:0]);
      b_ext = src2_signed(op_q)
            ? XLEN'($signed(opnd_q[W32-1:0]))
            : XLEN'(opnd_q[W32-1:0]);
    end
    neg_a   = src1_signed(op_q) && a_ext[XLEN-1];
    neg_b   = src2_signed(op_q) && b_ext[XLEN-1];
    mag_a   = neg_a ? -a_ext : a_ext;
    mag_b   = neg_b ? -b_ext : b_ext;
    min_neg = ~((XLEN'(1) << (w_q ? W32 - 1 : XLEN - 1))
              - XLEN'(1));
    b_zero  = is_div && (b_ext == '0);
    ovf     = ((op_q == MDT_DIV) || (op_q == MDT_REM)) &&
              (a_ext == min_neg) && (&b_ext);
    fast    = b_zero || ovf;
    if (b_zero) begin
      fast_val = is_rem ? a_ext : '1;
    end else begin
      fast_val = is_rem ? '0 : a_ext;
    end
  end

  // sign fixup used in FIXUP
  always_comb begin
    prod = res_neg_q ? (~acc_q + 1'b1) : acc_q;
    quo  = acc_q[XLEN-1:0];
    rem  = acc_q[2*XLEN-1:XLEN];
    unique case (op_q)
      MDT_MUL: begin
        // a W-mode product sits XLEN-32 bits up
        fix_val = w_q ? prod[SHW +: XLEN] : prod[XLEN-1:0];
      end
      MDT_MULH, MDT_MULHSU, MDT_MULHU: begin
        fix_val = prod[XLEN +: XLEN];
      end
      MDT_DIV, MDT_DIVU: begin
        fix_val = res_neg_q ? -quo : quo;
      end
      default: begin
        fix_val = res_neg_q ? -rem : rem;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q   <= IDLE;
      op_q      <= MDT_MUL;
      w_q       <= 1'b0;
      res_neg_q <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      w_q       <= w_d;
      res_neg_q <= res_neg_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      result_q  <= result_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (accept) state_d = PREP;
        PREP:    state_d = fast ? DONE : CALC;
        CALC:    if (calc_last) state_d = FIXUP;
        FIXUP:   state_d = DONE;
        DONE:    if (outReady) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    inReady  = state_q == IDLE;
    outValid = state_q == DONE;
    result   = result_q;
  end

  always_comb begin
    op_d      = op_q;
    w_d       = w_q;
    res_neg_d = res_neg_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    result_d  = result_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          op_d   = mulDivType;
          w_d    = isWord && (XLEN == 64);
          acc_d  = {XLEN'(0), src1};
          opnd_d = src2;
        end
      end
      PREP: begin
        res_neg_d = is_rem ? neg_a : (neg_a ^ neg_b);
        cnt_d     = '0;
        if (fast) begin
          result_d = fmt(fast_val, w_q);
        end else if (is_div) begin
          // W-mode dividend is left-aligned so W steps consume it
          acc_d  = {XLEN'(0), w_q ? (mag_a << SHW) : mag_a};
          opnd_d = mag_b;
        end else begin
          acc_d  = {XLEN'(0), mag_b};
          opnd_d = mag_a;
        end
      end
      CALC: begin
        acc_d = chain[STEP_BITS];
        cnt_d = calc_last ? '0 : cnt_q + 1'b1;
      end
      FIXUP: begin
        result_d = fmt(fix_val, w_q);
      end
      default: ;
    endcase
    if (flush) cnt_d = '0;
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: XLEN=32/STEP_BITS=1 and
// XLEN=64/STEP_BITS=4 instances checked against hand-computed values.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  logic        clk  = 1'b0;
  logic        rstN = 1'b0;
  logic        in_valid_a = 1'b0;
  logic        in_valid_b = 1'b0;
  MulDivType   op = MDT_MUL;
  logic        is_word = 1'b0;
  logic [63:0] s1 = '0;
  logic [63:0] s2 = '0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready_a, in_ready_b;
  logic        out_valid_a, out_valid_b;
  logic [31:0] res_a;
  logic [63:0] res_b;
  logic        sel = 1'b0;
  logic        cur_ready, cur_valid;
  logic [63:0] cur_res;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  assign cur_ready = sel ? in_ready_b : in_ready_a;
  assign cur_valid = sel ? out_valid_b : out_valid_a;
  assign cur_res   = sel ? res_b : {32'h0, res_a};

  mul_div_unit #(.XLEN(32), .STEP_BITS(1)) u_dut32 (
    .clk       (clk),
    .rstN      (rstN),
    .inValid   (in_valid_a),
    .inReady   (in_ready_a),
    .mulDivType(op),
    .isWord    (is_word),
    .src1      (s1[31:0]),
    .src2      (s2[31:0]),
    .flush     (flush),
    .outValid  (out_valid_a),
    .outReady  (out_ready),
    .result    (res_a)
  );

  mul_div_unit #(.XLEN(64), .STEP_BITS(4)) u_dut64 (
    .clk       (clk),
    .rstN      (rstN),
    .inValid   (in_valid_b),
    .inReady   (in_ready_b),
    .mulDivType(op),
    .isWord    (is_word),
    .src1      (s1),
    .src2      (s2),
    .flush     (flush),
    .outValid  (out_valid_b),
    .outReady  (out_ready),
    .result    (res_b)
  );

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_op(
    input string       tag,
    input logic        s,
    input MulDivType   t,
    input logic        w,
    input logic [63:0] a,
    input logic [63:0] b,
    input logic [63:0] exp,
    input int          exp_lat
  );
    int lat;
    int guard;
    sel = s; op = t; is_word = w; s1 = a; s2 = b;
    guard = 0;
    while (!cur_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (s) in_valid_b = 1'b1;
    else   in_valid_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    lat = 1;
    while (!cur_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " lat"}, 64'(lat), 64'(exp_lat));
    check({tag, " res"}, cur_res, exp);
    repeat (2) @(negedge clk);
    check({tag, " hold_v"}, 64'(cur_valid), 64'd1);
    check({tag, " hold_r"}, cur_res, exp);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " taken"}, {62'b0, cur_valid, cur_ready}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic seen;
    repeat (3) @(negedge clk);
    check("rst rdy32", 64'(in_ready_a), 64'd1);
    check("rst val32", 64'(out_valid_a), 64'd0);
    check("rst res32", 64'(res_a), 64'd0);
    check("rst rdy64", 64'(in_ready_b), 64'd1);
    check("rst res64", res_b, 64'd0);
    rstN = 1'b1;

    do_op("div100_7", 0, MDT_DIV, 0, 100, 7, 14, 35);
    do_op("rem100_7", 0, MDT_REM, 0, 100, 7, 2, 35);
    do_op("div_ovf", 0, MDT_DIV, 0, 64'h8000_0000,
          64'hFFFF_FFFF, 64'h8000_0000, 2);
    do_op("rem_ovf", 0, MDT_REM, 0, 64'h8000_0000,
          64'hFFFF_FFFF, 0, 2);
    do_op("divu_z", 0, MDT_DIVU, 0, 5, 0, 64'hFFFF_FFFF, 2);
    do_op("remu_z", 0, MDT_REMU, 0, 5, 0, 5, 2);
    do_op("mulhsu", 0, MDT_MULHSU, 0, 64'hFFFF_FFFF,
          64'hFFFF_FFFF, 64'hFFFF_FFFF, 35);
    do_op("mulhu", 0, MDT_MULHU, 0, 64'hFFFF_FFFF,
          64'hFFFF_FFFF, 64'hFFFF_FFFE, 35);
    do_op("div_n7_2", 0, MDT_DIV, 0, 64'hFFFF_FFF9, 2,
          64'hFFFF_FFFD, 35);
    do_op("rem_n7_2", 0, MDT_REM, 0, 64'hFFFF_FFF9, 2,
          64'hFFFF_FFFF, 35);
    do_op("mul_neg", 0, MDT_MUL, 0, 123, 64'hFFFF_FFFD,
          64'hFFFF_FE8F, 35);
    do_op("mulh_min", 0, MDT_MULH, 0, 64'h8000_0000,
          64'h8000_0000, 64'h4000_0000, 35);

    do_op("mulw64", 1, MDT_MUL, 1, 64'h7FFF_FFFF, 2,
          64'hFFFF_FFFF_FFFF_FFFE, 11);
    do_op("divu64", 1, MDT_DIVU, 0, 64'h1_0000_0000, 3,
          64'h5555_5555, 19);
    do_op("divw64", 1, MDT_DIV, 1, 64'h1234_5678_FFFF_FFF9, 2,
          64'hFFFF_FFFF_FFFF_FFFD, 11);
    do_op("divw_ovf", 1, MDT_DIV, 1, 64'h8000_0000,
          64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 2);
    do_op("mulhu64", 1, MDT_MULHU, 0, 64'hFFFF_FFFF_FFFF_FFFF,
          2, 1, 19);
    do_op("remuw_z", 1, MDT_REMU, 1, 64'h0000_0000_FFFF_FFF0,
          0, 64'hFFFF_FFFF_FFFF_FFF0, 2);

    // flush in the middle of an iteration
    sel = 0; op = MDT_DIV; is_word = 0; s1 = 100; s2 = 7;
    in_valid_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid_a = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush val", 64'(cur_valid), 64'd0);
    check("flush rdy", 64'(cur_ready), 64'd1);
    do_op("div9_3", 0, MDT_DIV, 0, 9, 3, 3, 35);

    // flush together with the request cancels it
    s1 = 5; s2 = 0; op = MDT_DIVU;
    in_valid_a = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid_a = 1'b0;
    flush = 1'b0;
    check("flush_acc rdy", 64'(cur_ready), 64'd1);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen = seen | cur_valid;
    end
    check("flush_acc none", 64'(seen), 64'd0);

    // asynchronous reset during an iteration
    op = MDT_DIV; s1 = 100; s2 = 7;
    in_valid_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid_a = 1'b0;
    repeat (5) @(negedge clk);
    rstN = 1'b0;
    #1;
    check("arst val", 64'(out_valid_a), 64'd0);
    check("arst rdy", 64'(in_ready_a), 64'd1);
    check("arst res", 64'(res_a), 64'd0);
    @(negedge clk);
    rstN = 1'b1;
    do_op("post_rst", 0, MDT_DIVU, 0, 9, 2, 4, 35);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
